// File: rtl/spi_status_responder.sv
// spi_status_responder: SPI mode-0 slave returning a header/status/counter/checksum frame on MISO
module spi_status_responder #(
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter logic [7:0] CMD_STATUS = 8'h3F,
  parameter logic [7:0] FILL       = 8'hFF
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       mosi,
  input  logic       led_state,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] last_cmd,
  output logic [7:0] frame_cnt
);
  logic       clr;
  logic [7:0] rx_shift_q, rx_shift_d, rx_word;
  logic [2:0] rx_cnt_q, rx_cnt_d;
  logic [7:0] last_cmd_q, last_cmd_d, frame_cnt_q, frame_cnt_d;
  logic       led_snap_q, led_snap_d, cmd_done;
  logic [7:0] tx_shift_q, tx_shift_d, byte1, byte3, next_byte;
  logic [2:0] tx_cnt_q, tx_cnt_d, byte_idx_q, byte_idx_d, nxt_idx;
  assign clr = reset | cs_n;
  always_comb begin
    rx_word     = {rx_shift_q[6:0], mosi};
    cmd_done    = ~cs_n && rx_cnt_q == 3'd7 && byte_idx_q == 3'd0;
    rx_shift_d  = rx_word;
    rx_cnt_d    = rx_cnt_q + 3'd1;
    last_cmd_d  = cmd_done ? rx_word : last_cmd_q;
    frame_cnt_d = cmd_done ? frame_cnt_q + 8'd1 : frame_cnt_q;
    led_snap_d  = cmd_done ? led_state : led_snap_q;
  end
  always_ff @(posedge sclk or posedge clr)
    if (clr) begin
      rx_shift_q <= '0;
      rx_cnt_q   <= '0;
    end else begin
      rx_shift_q <= rx_shift_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  // Command results survive cs_n deassertion; only reset clears them.
  always_ff @(posedge sclk or posedge reset)
    if (reset) begin
      last_cmd_q  <= '0;
      frame_cnt_q <= '0;
      led_snap_q  <= 1'b0;
    end else begin
      last_cmd_q  <= last_cmd_d;
      frame_cnt_q <= frame_cnt_d;
      led_snap_q  <= led_snap_d;
    end
  always_comb begin
    byte1 = last_cmd_q == CMD_STATUS ? {7'b0011000, led_snap_q} :
            (last_cmd_q == 8'h30 || last_cmd_q == 8'h31) ? 8'h06 : 8'h15;
    byte3 = HEADER ^ byte1 ^ frame_cnt_q;
    nxt_idx = byte_idx_q + 3'd1;
    next_byte = nxt_idx == 3'd1 ? byte1 :
                nxt_idx == 3'd2 ? frame_cnt_q :
                nxt_idx == 3'd3 ? byte3 : FILL;
    tx_shift_d = tx_cnt_q == 3'd7 ? next_byte : {tx_shift_q[6:0], 1'b0};
    tx_cnt_d   = tx_cnt_q + 3'd1;
    byte_idx_d = (tx_cnt_q == 3'd7 && byte_idx_q != 3'd4) ? nxt_idx : byte_idx_q;
  end
  always_ff @(negedge sclk or posedge clr)
    if (clr) begin
      tx_shift_q <= HEADER;
      tx_cnt_q   <= '0;
      byte_idx_q <= '0;
    end else begin
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      byte_idx_q <= byte_idx_d;
    end
  assign miso      = tx_shift_q[7];
  assign miso_oe   = ~cs_n;
  assign last_cmd  = last_cmd_q;
  assign frame_cnt = frame_cnt_q;
endmodule
